// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-counter datapath: result width,
// display ceiling, default clock rate and the gate FSM state encoding.
package freq_pkg;

  localparam int FREQ_W    = 14;
  localparam int MAX_COUNT = 9999;
  localparam int CLK_HZ    = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_GATE = 2'd2
  } state_t;

endpackage

// File: rtl/freq_gate_counter_sync.sv
// Brings the asynchronous measured signal into the iClk domain and emits a
// one-cycle pulse for each rising edge (sync2 high while the delay flop is low).
module sig_sync_edge (
  input  logic iClk,
  input  logic iReset,
  input  logic iSignal,
  output logic oEdge
);

  logic sync1;
  logic sync2;
  logic delay;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      delay <= 1'b0;
    end else begin
      sync1 <= iSignal;
      sync2 <= sync1;
      delay <= sync2;
    end
  end

  assign oEdge = sync2 & ~delay;

endmodule

// File: rtl/freq_gate_counter.sv
// Counts rising edges of iSignal over back-to-back gate windows of GATE_CYCLES
// clocks and latches the saturated count with a one-cycle oValid strobe.
module freq_gate_counter #(
  parameter int CLK_HZ      = freq_pkg::CLK_HZ,
  parameter int GATE_CYCLES = CLK_HZ,
  parameter int MAX_COUNT   = freq_pkg::MAX_COUNT
) (
  input  logic                          iClk,
  input  logic                          iReset,
  input  logic                          iEnable,
  input  logic                          iSignal,
  output logic [freq_pkg::FREQ_W-1:0]   oFrec,
  output logic                          oValid,
  output logic                          oOverflow,
  output logic                          oBusy,
  output freq_pkg::state_t              oState
);

  import freq_pkg::*;

  localparam int                TW       = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0]     LAST_T   = TW'(GATE_CYCLES - 1);
  localparam logic [FREQ_W-1:0] CEIL     = FREQ_W'(MAX_COUNT);

  state_t              state;
  state_t              stateNext;
  logic                armCnt;
  logic [TW-1:0]       timer;
  logic [FREQ_W-1:0]   edgeCnt;
  logic                ovf;
  logic                edgePulse;

  logic                isLast;
  logic                atCeil;
  logic [FREQ_W-1:0]   satCount;
  logic                ovfFinal;

  sig_sync_edge u_sync (
    .iClk    (iClk),
    .iReset  (iReset),
    .iSignal (iSignal),
    .oEdge   (edgePulse)
  );

  // Values the window would hold after this cycle's edge; used both for the
  // running count and for the latch, so the final-cycle edge is included.
  assign isLast   = (state == ST_GATE) && (timer == LAST_T);
  assign atCeil   = (edgeCnt == CEIL);
  assign satCount = (edgePulse && !atCeil) ? edgeCnt + FREQ_W'(1) : edgeCnt;
  assign ovfFinal = ovf | (edgePulse & atCeil);

  always_ff @(posedge iClk) begin
    if (iReset) state <= ST_IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (iEnable) stateNext = ST_ARM;
      ST_ARM: begin
        if (!iEnable)    stateNext = ST_IDLE;
        else if (armCnt) stateNext = ST_GATE;
      end
      ST_GATE: begin
        // The latch cycle always completes, even if enable just dropped.
        if (isLast)        stateNext = iEnable ? ST_GATE : ST_IDLE;
        else if (!iEnable) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      armCnt    <= 1'b0;
      timer     <= '0;
      edgeCnt   <= '0;
      ovf       <= 1'b0;
      oFrec     <= '0;
      oValid    <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      oValid <= 1'b0;
      armCnt <= (state == ST_ARM) && (stateNext == ST_ARM);
      if (state != ST_GATE || stateNext != ST_GATE || isLast) begin
        timer   <= '0;
        edgeCnt <= '0;
        ovf     <= 1'b0;
      end else begin
        timer   <= timer + TW'(1);
        edgeCnt <= satCount;
        ovf     <= ovfFinal;
      end
      if (isLast) begin
        oFrec     <= satCount;
        oOverflow <= ovfFinal;
        oValid    <= 1'b1;
      end
    end
  end

  assign oBusy  = (state == ST_GATE);
  assign oState = state;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: two instances (default ceiling and ceiling 5)
// share stimulus; per-window expected results are queued and checked on oValid.
module tb_freq_gate_counter;
  import freq_pkg::*;

  localparam int G       = 100;
  localparam int SAT_MAX = 5;
  localparam int W       = FREQ_W + 1;

  logic iClk = 1'b0;
  logic iReset, iEnable, iSignal;

  logic [FREQ_W-1:0] frecM, frecS;
  logic validM, validS, ovfM, ovfS, busyM, busyS;
  state_t stateM, stateS;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_s_q[$];
  logic [W-1:0] lastM, lastS, expM, expS;
  int vcyc_q[$];

  freq_gate_counter #(.CLK_HZ(1000), .GATE_CYCLES(G), .MAX_COUNT(MAX_COUNT)) dut (
    .iClk(iClk), .iReset(iReset), .iEnable(iEnable), .iSignal(iSignal),
    .oFrec(frecM), .oValid(validM), .oOverflow(ovfM), .oBusy(busyM), .oState(stateM)
  );

  freq_gate_counter #(.CLK_HZ(1000), .GATE_CYCLES(G), .MAX_COUNT(SAT_MAX)) dutSat (
    .iClk(iClk), .iReset(iReset), .iEnable(iEnable), .iSignal(iSignal),
    .oFrec(frecS), .oValid(validS), .oOverflow(ovfS), .oBusy(busyS), .oState(stateS)
  );

  // clock / cycle counter
  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  // scoreboard monitor
  always @(negedge iClk) begin
    if (validM) begin
      vcyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL main_unexpected_valid got frec=%0d ovf=%0b cyc=%0d required no pulse", frecM, ovfM, cyc);
      end else begin
        expM = exp_q.pop_front();
        if ({ovfM, frecM} !== expM) begin
          errors++;
          $display("FAIL main_result got ovf=%0b frec=%0d required ovf=%0b frec=%0d",
                   ovfM, frecM, expM[W-1], expM[FREQ_W-1:0]);
        end
      end
    end
    if (validS) begin
      checks++;
      if (exp_s_q.size() == 0) begin
        errors++;
        $display("FAIL sat_unexpected_valid got frec=%0d ovf=%0b cyc=%0d required no pulse", frecS, ovfS, cyc);
      end else begin
        expS = exp_s_q.pop_front();
        if ({ovfS, frecS} !== expS) begin
          errors++;
          $display("FAIL sat_result got ovf=%0b frec=%0d required ovf=%0b frec=%0d",
                   ovfS, frecS, expS[W-1], expS[FREQ_W-1:0]);
        end
      end
    end
  end

  function automatic logic pattern(input int mode, input int phase, input int r);
    case (mode)
      0:       return ((r + phase) % 10) < 5;
      1:       return (r < G) ? ((r % 4) < 2) : ((r % 40) < 20);
      2:       return (r >= 20 && r < 40) || (r >= 99);
      default: return 1'b1;
    endcase
  endfunction

  task automatic push_window(input int cnt);
    int m, s;
    m = (cnt > MAX_COUNT) ? MAX_COUNT : cnt;
    s = (cnt > SAT_MAX) ? SAT_MAX : cnt;
    lastM = {cnt > MAX_COUNT, m[FREQ_W-1:0]};
    lastS = {cnt > SAT_MAX, s[FREQ_W-1:0]};
    exp_q.push_back(lastM);
    exp_s_q.push_back(lastS);
  endtask

  // Driver: call just after a rising edge. A rise driven r cycles after the
  // edge that first samples iEnable high belongs to window r/G; rises at r<0
  // fall in the arm phase and are not counted.
  task automatic run_enabled(input int mode, input int phase, input int nCyc,
                             input int pushWin, input int rstAt, output int e0);
    int cnt;
    logic prev, cur;
    cnt = 0;
    prev = iSignal;
    e0 = 0;
    iEnable = 1'b1;
    for (int r = 0; r < nCyc; r++) begin
      @(posedge iClk); #1;
      if (r == 0) e0 = cyc;
      cur = pattern(mode, phase, r);
      if (cur && !prev) cnt++;
      iSignal = cur;
      prev = cur;
      if (r == rstAt) iReset = 1'b1;
      if (r % G == G - 1) begin
        if (r / G < pushWin) push_window(cnt);
        cnt = 0;
      end
    end
    iEnable = 1'b0;
  endtask

  task automatic wait_drain(input int maxCyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_s_q.size() != 0) && n < maxCyc) begin
      @(posedge iClk);
      n++;
    end
    @(negedge iClk);
    checks++;
    if (exp_q.size() != 0 || exp_s_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending main=%0d sat=%0d required 0", exp_q.size(), exp_s_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [W-1:0] wantM, input logic [W-1:0] wantS);
    checks += 4;
    if (busyM !== 1'b0 || busyS !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy got %0b/%0b required 0/0", tag, busyM, busyS);
    end
    if (validM !== 1'b0 || validS !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid got %0b/%0b required 0/0", tag, validM, validS);
    end
    if ({ovfM, frecM} !== wantM) begin
      errors++;
      $display("FAIL %s_main_hold got %0h required %0h", tag, {ovfM, frecM}, wantM);
    end
    if ({ovfS, frecS} !== wantS) begin
      errors++;
      $display("FAIL %s_sat_hold got %0h required %0h", tag, {ovfS, frecS}, wantS);
    end
  endtask

  task automatic test_reset;
    iReset = 1'b1;
    iEnable = 1'b0;
    iSignal = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    check_idle_outputs("reset", '0, '0);
    checks++;
    if (stateM !== ST_IDLE || stateS !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d/%0d required %0d", stateM, stateS, ST_IDLE);
    end
    iReset = 1'b0;
  endtask

  task automatic test_square;
    int e0, ph;
    ph = $urandom_range(0, 9);
    vcyc_q.delete();
    @(posedge iClk); #1;
    // enable drops on the third latch cycle: that window still completes
    run_enabled(0, ph, 3 * G + 2, 3, -1, e0);
    wait_drain(200);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (k >= vcyc_q.size() || vcyc_q[k] != e0 + 2 + G * (k + 1)) begin
        errors++;
        $display("FAIL square_valid_timing window %0d got cyc=%0d required %0d", k,
                 (k < vcyc_q.size()) ? vcyc_q[k] : -1, e0 + 2 + G * (k + 1));
      end
    end
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    check_idle_outputs("square_end", lastM, lastS);
  endtask

  task automatic test_drop_mid;
    int e0;
    @(posedge iClk); #1;
    run_enabled(0, 0, 51, 0, -1, e0);
    @(posedge iClk);
    @(negedge iClk);
    check_idle_outputs("drop_mid", lastM, lastS);
    repeat (150) @(posedge iClk);
    @(negedge iClk);
    check_idle_outputs("drop_mid_later", lastM, lastS);
  endtask

  task automatic test_saturation;
    int e0;
    @(posedge iClk); #1;
    run_enabled(1, 0, 2 * G + 2, 2, -1, e0);
    wait_drain(200);
  endtask

  task automatic test_latch_edge;
    int e0;
    iSignal = 1'b0;
    @(posedge iClk); #1;
    run_enabled(2, 0, 2 * G + 2, 2, -1, e0);
    wait_drain(200);
  endtask

  task automatic test_hold_high;
    int e0;
    iSignal = 1'b0;
    @(posedge iClk); #1;
    iSignal = 1'b1;
    run_enabled(3, 0, G + 2, 1, -1, e0);
    wait_drain(200);
  endtask

  task automatic test_reset_mid;
    int e0;
    iSignal = 1'b0;
    @(posedge iClk); #1;
    run_enabled(0, 0, G + 2, 0, G + 1, e0);
    @(posedge iClk);
    @(negedge iClk);
    check_idle_outputs("reset_mid", '0, '0);
    checks++;
    if (stateM !== ST_IDLE || stateS !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid_state got %0d/%0d required %0d", stateM, stateS, ST_IDLE);
    end
    iReset = 1'b0;
    repeat (20) @(posedge iClk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_square();
    test_drop_mid();
    test_saturation();
    test_latch_edge();
    test_hold_high();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
